// File: rtl/ssp_init_if.sv
// ssp_init_if: register/memory write channels of ssp_init_sequencer.
// SSP_INIT_VERIFY_EN adds the memory read-back channel and verify status.
interface ssp_init_if #(
  parameter int REG_WIDTH   = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int RA_W        = 5,
  parameter int MA_W        = 11
);
  logic                   reg_we;
  logic [RA_W-1:0]        reg_waddr;
  logic [REG_WIDTH-1:0]   reg_wdata;
  logic                   mem_we;
  logic [MA_W-1:0]        mem_waddr;
  logic [INSTR_WIDTH-1:0] mem_wdata;
`ifdef SSP_INIT_VERIFY_EN
  logic                   mem_re;
  logic [MA_W-1:0]        mem_raddr;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   verify_err;
  logic [MA_W-1:0]        err_addr;
`endif
  modport master (
    output reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata
`ifdef SSP_INIT_VERIFY_EN
    , output mem_re, mem_raddr, verify_err, err_addr, input mem_rdata
`endif
  );
  modport slave (
    input reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata
`ifdef SSP_INIT_VERIFY_EN
    , input mem_re, mem_raddr, verify_err, err_addr, output mem_rdata
`endif
  );
endinterface

// File: rtl/ssp_init_sequencer.sv
// ssp_init_sequencer: power-on fill of register file (zeros) and instruction memory (NOPs), holding the core until done.
// SSP_INIT_VERIFY_EN adds a read-back pass over the memory after the fill.
module ssp_init_sequencer #(
  parameter int         REG_COUNT   = 32,
  parameter int         REG_WIDTH   = 32,
  parameter int         MEM_DEPTH   = 1028,
  parameter int         INSTR_WIDTH = 32,
  parameter logic [5:0] NOP_OPCODE  = 6'b111111,
  parameter bit         AUTO_START  = 1'b1,
  parameter int         RA_W        = $clog2(REG_COUNT),
  parameter int         MA_W        = $clog2(MEM_DEPTH)
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       start,
  output logic       core_hold,
  output logic       busy,
  output logic       done,
  ssp_init_if.master bus
);
  localparam logic [RA_W-1:0]        REG_LAST = RA_W'(REG_COUNT - 1);
  localparam logic [MA_W-1:0]        MEM_LAST = MA_W'(MEM_DEPTH - 1);
  localparam logic [INSTR_WIDTH-1:0] NOP      = {NOP_OPCODE, {(INSTR_WIDTH-6){1'b0}}};
  typedef enum logic [1:0] {IDLE, CLEAR, VERIFY, DONE} state_t;
  state_t state_q, state_d;
  logic reg_we_q, reg_we_d, mem_we_q, mem_we_d, go, fill_end;
  logic [RA_W-1:0] reg_waddr_q, reg_waddr_d;
  logic [MA_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [INSTR_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef SSP_INIT_VERIFY_EN
  logic mem_re_q, mem_re_d, cmp_q, cmp_d, verify_err_q, verify_err_d, bad;
  logic [MA_W-1:0] mem_raddr_q, mem_raddr_d, cmp_addr_q, cmp_addr_d, err_addr_q, err_addr_d;
`endif
  // Each channel walks its own range and parks on its last address; the fill ends when both have parked.
  always_comb begin
    go = state_q == IDLE ? (AUTO_START || start) : (state_q == DONE && start);
    state_d = state_q;
    reg_we_d = reg_we_q && reg_waddr_q != REG_LAST;
    mem_we_d = mem_we_q && mem_waddr_q != MEM_LAST;
    reg_waddr_d = reg_we_d ? reg_waddr_q + 1'b1 : reg_waddr_q;
    mem_waddr_d = mem_we_d ? mem_waddr_q + 1'b1 : mem_waddr_q;
    mem_wdata_d = NOP;
    fill_end = state_q == CLEAR && !reg_we_d && !mem_we_d;
`ifdef SSP_INIT_VERIFY_EN
    mem_re_d = mem_re_q && mem_raddr_q != MEM_LAST;
    mem_raddr_d = mem_re_d ? mem_raddr_q + 1'b1 : mem_raddr_q;
    cmp_d = mem_re_q;
    cmp_addr_d = mem_raddr_q;
    bad = cmp_q && bus.mem_rdata != NOP;
    verify_err_d = !go && (verify_err_q || bad);
    err_addr_d = bad && !verify_err_q ? cmp_addr_q : err_addr_q;
    if (fill_end) begin
      state_d = VERIFY;
      mem_re_d = 1'b1;
      mem_raddr_d = '0;
    end else if (state_q == VERIFY && cmp_q && !mem_re_q) state_d = DONE;
`else
    if (fill_end) state_d = DONE;
`endif
    if (go) begin
      state_d = CLEAR;
      reg_we_d = 1'b1;
      mem_we_d = 1'b1;
      reg_waddr_d = '0;
      mem_waddr_d = '0;
    end
  end
  always_ff @(posedge clk1 or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      reg_waddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= NOP;
`ifdef SSP_INIT_VERIFY_EN
      mem_re_q <= 1'b0;
      mem_raddr_q <= '0;
      cmp_q <= 1'b0;
      cmp_addr_q <= '0;
      verify_err_q <= 1'b0;
      err_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      reg_we_q <= reg_we_d;
      mem_we_q <= mem_we_d;
      reg_waddr_q <= reg_waddr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef SSP_INIT_VERIFY_EN
      mem_re_q <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
      cmp_q <= cmp_d;
      cmp_addr_q <= cmp_addr_d;
      verify_err_q <= verify_err_d;
      err_addr_q <= err_addr_d;
`endif
    end
  assign busy = state_q == CLEAR || state_q == VERIFY;
  assign done = state_q == DONE;
  assign bus.reg_we = reg_we_q;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_wdata = {REG_WIDTH{1'b0}};
  assign bus.mem_we = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef SSP_INIT_VERIFY_EN
  assign core_hold = !done || verify_err_q;
  assign bus.mem_re = mem_re_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.verify_err = verify_err_q;
  assign bus.err_addr = err_addr_q;
`else
  assign core_hold = !done;
`endif
endmodule

// File: tb/tb_ssp_init_sequencer.sv
// tb_ssp_init_sequencer: two sequencers (auto-start 32x1028, start-driven 64x16) checked every cycle
// against a model that tracks only the cycle index of the current run.
module tb_ssp_init_sequencer;
  localparam int RC0 = 32, MD0 = 1028, RC1 = 64, MD1 = 16, BAD = 700;
`ifdef SSP_INIT_VERIFY_EN
  localparam int LIT0 = 2057, LIT1 = 81;
`else
  localparam int LIT0 = 1028, LIT1 = 64;
`endif
  logic clk1 = 0, reset = 0, start0 = 0, start1 = 0, rnd = 0, stop = 0;
  logic hold0, busy0, done0, hold1, busy1, done1;
  logic mre0, mre1, ve0, ve1, ve0_e;
  logic [31:0] mra0, mra1, ea0, ea1;
  int checks = 0, errors = 0, k = 0, n0 = -1, n1 = -1, rw0 = 0, mw0 = 0;
  always #5 clk1 = ~clk1;
  ssp_init_if #(.REG_WIDTH(32), .INSTR_WIDTH(32), .RA_W(5), .MA_W(11)) bus0();
  ssp_init_if #(.REG_WIDTH(32), .INSTR_WIDTH(32), .RA_W(6), .MA_W(4)) bus1();
  ssp_init_sequencer #(.REG_COUNT(RC0), .MEM_DEPTH(MD0)) dut0 (
    .clk1(clk1), .reset(reset), .start(start0), .core_hold(hold0), .busy(busy0), .done(done0), .bus(bus0));
  ssp_init_sequencer #(.REG_COUNT(RC1), .MEM_DEPTH(MD1), .AUTO_START(1'b0)) dut1 (
    .clk1(clk1), .reset(reset), .start(start1), .core_hold(hold1), .busy(busy1), .done(done1), .bus(bus1));
`ifdef SSP_INIT_VERIFY_EN
  logic [31:0] mem0 [MD0];
  logic [31:0] mem1 [MD1];
  always @(posedge clk1) begin
    if (bus0.mem_we) mem0[bus0.mem_waddr] <= bus0.mem_waddr == 11'(BAD) ? bus0.mem_wdata ^ 32'h1 : bus0.mem_wdata;
    if (bus0.mem_re) bus0.mem_rdata <= mem0[bus0.mem_raddr];
    if (bus1.mem_we) mem1[bus1.mem_waddr] <= bus1.mem_wdata;
    if (bus1.mem_re) bus1.mem_rdata <= mem1[bus1.mem_raddr];
  end
  assign mre0 = bus0.mem_re;
  assign mre1 = bus1.mem_re;
  assign mra0 = 32'(bus0.mem_raddr);
  assign mra1 = 32'(bus1.mem_raddr);
  assign ve0 = bus0.verify_err;
  assign ve1 = bus1.verify_err;
  assign ea0 = 32'(bus0.err_addr);
  assign ea1 = 32'(bus1.err_addr);
  assign ve0_e = n0 >= (RC0 > MD0 ? RC0 : MD0) + BAD + 2;
`else
  assign {mre0, mre1, ve0, ve1, ve0_e} = '0;
  assign {mra0, mra1, ea0, ea1} = '0;
`endif
  function automatic int run_len(int rc, int md);
    int c;
    c = rc > md ? rc : md;
`ifdef SSP_INIT_VERIFY_EN
    return c + md + 1;
`else
    return c;
`endif
  endfunction
  function automatic int next_n(int n, logic auto_s, logic st, int len);
    if (n < 0) return (auto_s || st) ? 0 : -1;
    if (n >= len) return st ? 0 : n;
    return n + 1;
  endfunction
  // n = cycle index within the current run, -1 = never started since reset
  always @(posedge clk1 or negedge reset)
    if (!reset) begin
      n0 <= -1;
      n1 <= -1;
    end else begin
      n0 <= next_n(n0, 1'b1, start0, run_len(RC0, MD0));
      n1 <= next_n(n1, 1'b0, start1, run_len(RC1, MD1));
    end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_dut(string p, int n, int rc, int md, logic ve_e,
      logic rwe, logic [31:0] rwa, logic [31:0] rwd, logic mwe, logic [31:0] mwa, logic [31:0] mwd,
      logic bsy, logic dn, logic hold, logic mre, logic [31:0] mra, logic ve, logic [31:0] ea);
    int c, len;
    logic clr, ver, fin;
    c = rc > md ? rc : md;
    len = run_len(rc, md);
    clr = n >= 0 && n < c;
    ver = n >= c && n < len;
    fin = n >= len;
    chk({p, ".reg_we"}, rwe, clr && n < rc);
    chk({p, ".mem_we"}, mwe, clr && n < md);
    if (n < 0) begin
      chk({p, ".reg_waddr_idle"}, rwa, 0);
      chk({p, ".mem_waddr_idle"}, mwa, 0);
    end
    if (clr) begin
      chk({p, ".reg_waddr"}, rwa, n < rc ? n : rc - 1);
      chk({p, ".mem_waddr"}, mwa, n < md ? n : md - 1);
    end
    if (rwe) chk({p, ".reg_wdata"}, rwd, 0);
    if (mwe) chk({p, ".mem_wdata"}, mwd, 32'hFC000000);
    chk({p, ".busy"}, bsy, clr || ver);
    chk({p, ".done"}, dn, fin);
    chk({p, ".core_hold"}, hold, !(fin && !ve_e));
`ifdef SSP_INIT_VERIFY_EN
    chk({p, ".mem_re"}, mre, ver && n - c < md);
    if (ver) chk({p, ".mem_raddr"}, mra, n - c < md ? n - c : md - 1);
    chk({p, ".verify_err"}, ve, ve_e);
    if (ve_e) chk({p, ".err_addr"}, ea, BAD);
`endif
  endtask
  always @(negedge clk1)
    if (!stop) begin
      cmp_dut("d0", n0, RC0, MD0, ve0_e, bus0.reg_we, 32'(bus0.reg_waddr), bus0.reg_wdata, bus0.mem_we,
              32'(bus0.mem_waddr), bus0.mem_wdata, busy0, done0, hold0, mre0, mra0, ve0, ea0);
      cmp_dut("d1", n1, RC1, MD1, 1'b0, bus1.reg_we, 32'(bus1.reg_waddr), bus1.reg_wdata, bus1.mem_we,
              32'(bus1.mem_waddr), bus1.mem_wdata, busy1, done1, hold1, mre1, mra1, ve1, ea1);
      if (bus0.reg_we) rw0 <= rw0 + 1;
      if (bus0.mem_we) mw0 <= mw0 + 1;
    end
  task automatic step();
    @(negedge clk1);
    #2;
    start0 = 0;
    start1 = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
    k++;
  endtask
  initial begin
    #3;
    chk("rst.hold0", hold0, 1);
    chk("rst.busy0", busy0, 0);
    chk("rst.mem_waddr0", bus0.mem_waddr, 0);
    #29 reset = 1;
    #1 chk("pre_edge.reg_we0", bus0.reg_we, 0);
    step();
    k = 0;
    chk("entry.busy0", busy0, 1);
    chk("entry.reg_we0", bus0.reg_we, 1);
    chk("entry.reg_waddr0", bus0.reg_waddr, 0);
    chk("entry.mem_wdata0", bus0.mem_wdata, 32'hFC000000);
    repeat (9) step();
    chk("idle.reg_we1", bus1.reg_we, 0);
    chk("idle.mem_we1", bus1.mem_we, 0);
    chk("idle.busy1", busy1, 0);
    chk("idle.hold1", hold1, 1);
    start1 = 1;
    step();
    repeat (20) step();
    chk("n20.reg_we1", bus1.reg_we, 1);
    chk("n20.reg_waddr1", bus1.reg_waddr, 20);
    chk("n20.mem_we1", bus1.mem_we, 0);
    chk("n20.mem_waddr1", bus1.mem_waddr, 15);
    start1 = 1;
    repeat (20) step();
    chk("busy_start.reg_waddr1", bus1.reg_waddr, 40);
    chk("busy_start.busy1", busy1, 1);
    repeat (LIT1 - 41) step();
    chk("last.done1", done1, 0);
    step();
    chk("end.done1", done1, 1);
    chk("end.busy1", busy1, 0);
    chk("end.hold1", hold1, 0);
    start1 = 1;
    step();
    chk("rerun.done1", done1, 0);
    chk("rerun.hold1", hold1, 1);
    chk("rerun.busy1", busy1, 1);
    chk("rerun.reg_waddr1", bus1.reg_waddr, 0);
    rnd = 1;
    while (!done0 && k < 8000) step();
    chk("d0.fill_cycles", k, LIT0);
    chk("d0.reg_writes", rw0, 32);
    chk("d0.mem_writes", mw0, 1028);
`ifdef SSP_INIT_VERIFY_EN
    chk("d0.hold_after_err", hold0, 1);
    chk("d0.verify_err", ve0, 1);
    chk("d0.err_addr", ea0, 700);
`else
    chk("d0.hold_done", hold0, 0);
`endif
    repeat (3) step();
    start0 = 1;
    step();
    chk("rerun.done0", done0, 0);
    chk("rerun.hold0", hold0, 1);
    chk("rerun.busy0", busy0, 1);
    chk("rerun.mem_waddr0", bus0.mem_waddr, 0);
    repeat (500) step();
    reset = 0;
    #1;
    chk("abort.reg_we0", bus0.reg_we, 0);
    chk("abort.mem_we0", bus0.mem_we, 0);
    chk("abort.reg_waddr0", bus0.reg_waddr, 0);
    chk("abort.mem_waddr0", bus0.mem_waddr, 0);
    chk("abort.busy0", busy0, 0);
    chk("abort.done0", done0, 0);
    chk("abort.hold0", hold0, 1);
    repeat (2) step();
    reset = 1;
    step();
    k = 0;
    chk("restart.reg_we0", bus0.reg_we, 1);
    chk("restart.reg_waddr0", bus0.reg_waddr, 0);
    chk("restart.mem_waddr0", bus0.mem_waddr, 0);
    while (!done0 && k < 8000) step();
    chk("d0.refill_cycles", k, LIT0);
    rnd = 0;
    repeat (100) step();
    stop = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssp_init_sequencer.md
Name: ssp_init_sequencer

Overview:
Hardware power-on initialiser for the superscalar processor. After reset, it fills every register-file entry with zero and every instruction-memory word with a NOP encoding, driving two independent write channels in parallel. It holds the core in reset (core_hold) until the fill completes. Width, depth and the fill pattern are parameterised, so the block covers any processor generation.

Parameters:
REG_COUNT, 32, number of register-file entries to clear
REG_WIDTH, 32, register data width
MEM_DEPTH, 1028, instruction-memory words to fill
INSTR_WIDTH, 32, instruction word width
NOP_OPCODE, 6'b111111, opcode placed in bits [INSTR_WIDTH-1 -: 6]; remaining bits zero
AUTO_START, 1, 1 = begin fill on reset release; 0 = wait for start
RA_W, $clog2(REG_COUNT), register address width
MA_W, $clog2(MEM_DEPTH), memory address width

Ports:
clk1  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low; 0 = in reset
start  input  1  single-cycle request to (re)run the fill
reg_we  output  1  register-file write enable
reg_waddr  output  RA_W  register write address
reg_wdata  output  REG_WIDTH  always 0
mem_we  output  1  instruction-memory write enable
mem_waddr  output  MA_W  memory write address
mem_wdata  output  INSTR_WIDTH  {NOP_OPCODE, zeros}
core_hold  output  1  1 = processor must stay in reset
busy  output  1  fill or verify in progress
done  output  1  level; 1 after a completed fill, until the next run starts

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; both counters=0; reg_we=mem_we=0; addresses=0; busy=0; done=0; core_hold=1. Reset mid-fill aborts immediately. No partial-completion flag.
- States: IDLE, CLEAR, [VERIFY], DONE.
- IDLE -> CLEAR: on the first clk1 edge after reset release if AUTO_START=1; otherwise on start=1.
- CLEAR:
  - busy=1, core_hold=1.
  - Register channel: reg_we=1 with reg_waddr=0..REG_COUNT-1, one address per cycle.
  - Memory channel: mem_we=1 with mem_waddr=0..MEM_DEPTH-1, one address per cycle.
  - Both channels start on the same cycle. The shorter channel deasserts its write enable after its last address and holds that address.
  - CLEAR lasts exactly max(REG_COUNT, MEM_DEPTH) cycles.
- CLEAR exit: after the final write, go to DONE (or to VERIFY if compiled in).
- DONE:
  - we=0, busy=0, done=1.
  - core_hold drops to 0 on the same edge that sets done.
- start in DONE: re-enters CLEAR. done=0 and core_hold=1 on that edge; counters reload to 0.
- start while busy: ignored, not queued.
- Counters stop at the last index and never wrap past it. Non-power-of-two depths (e.g. 1028) must terminate at DEPTH-1, not at 2^MA_W-1.
- Write data is constant and registered. reg_wdata and mem_wdata are valid whenever the matching we=1.

Optional Feature:
- Macro: SSP_INIT_VERIFY_EN.
- When defined:
  - Added ports: mem_re output 1; mem_raddr output MA_W; mem_rdata input INSTR_WIDTH (1-cycle read latency); verify_err output 1; err_addr output MA_W.
  - After CLEAR, the FSM enters VERIFY. It issues reads 0..MEM_DEPTH-1 and compares each returned word with the NOP pattern one cycle later.
  - VERIFY lasts MEM_DEPTH+1 cycles.
  - On the first mismatch: verify_err=1 (sticky until the next run or reset) and err_addr captures the address.
  - VERIFY always runs to completion and then goes to DONE.
  - core_hold stays 1 when verify_err=1.
- When undefined: these ports are absent and CLEAR goes directly to DONE.

Test Plan:
- Defaults, AUTO_START=1, release reset at 30 ns:
  - 32 reg writes of 0 and 1028 mem writes of 0xFC000000 (addresses 0..1027).
  - done=1 and core_hold=0 exactly 1028 cycles after CLEAR entry.
- REG_COUNT=64, MEM_DEPTH=16:
  - mem_we drops after 16 cycles; reg_we continues to address 63.
  - CLEAR lasts 64 cycles.
- Reset pulled low at cycle 500 of CLEAR:
  - All outputs are at reset values in the same cycle.
  - After release, the fill restarts from address 0.
- AUTO_START=0:
  - No writes until start=1.
  - start pulsed during CLEAR has no effect.
  - start in DONE reruns the fill, and done falls on that edge.
- SSP_INIT_VERIFY_EN, memory model corrupts word 700:
  - verify_err=1 and err_addr=700.
  - done=1 after 1028+1029 cycles; core_hold remains 1.
- SSP_INIT_VERIFY_EN, clean memory:
  - verify_err=0 throughout; core_hold falls with done.
